reg_bank_arbiter: RTL and testbench

- Round-robin write arbiter that shares one bank of D-type storage registers among N_REQ requesters.
- Each requester posts an address and data with a level request. The arbiter grants one requester at a time, performs the write, and returns a one-cycle acknowledge.
- Read side is a single shared combinational port.
- Sits between requesting masters and the flip-flop register bank; the bank is instantiated inside this block.

---
 rtl/reg_bank_arbiter.sv | 143 ++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a 2**ADDR_W x DATA_W flip-flop bank; one shared combinational read port.
// Latency: req sampled -> gnt next cycle -> bank write + one-cycle ack the cycle after; one write per 2 cycles.
// Backpressure: requesters hold req until ack; optional write protect via `define REG_BANK_ARBITER_WPROT_EN.
module reg_bank_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   wr_addr,
   input  logic [N_REQ*DATA_W-1:0]   wr_data,
   output logic [N_REQ-1:0]          gnt,
   output logic [N_REQ-1:0]          ack,
   output logic                      busy,
`ifdef REG_BANK_ARBITER_WPROT_EN
   input  logic [(2**ADDR_W)-1:0]    wprot,
   output logic                      err,
`endif
   input  logic [ADDR_W-1:0]         rd_addr,
   output logic [DATA_W-1:0]         rd_data
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    gnt_q, gnt_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
   logic [DATA_W-1:0]   cap_data_q, cap_data_d;
   logic [DATA_W-1:0]   bank_q [DEPTH];
   logic                bank_we;
   logic [N_REQ-1:0]    elig;
   logic                found;
   logic [PTR_W-1:0]    winner;
`ifdef REG_BANK_ARBITER_WPROT_EN
   logic                err_q, err_d;
`endif

   // A requester whose ack is still high may drop req one edge late; mask it.
   assign elig = req & ~ack_q;

   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && elig[idx]) begin
            found  = 1'b1;
            winner = PTR_W'(idx);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = '0;
      ack_d      = '0;
      ptr_d      = ptr_q;
      win_d      = win_q;
      cap_addr_d = cap_addr_q;
      cap_data_d = cap_data_q;
      bank_we    = 1'b0;
`ifdef REG_BANK_ARBITER_WPROT_EN
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d      = N_REQ'(1) << winner;
               win_d      = winner;
               cap_addr_d = wr_addr[int'(winner)*ADDR_W +: ADDR_W];
               cap_data_d = wr_data[int'(winner)*DATA_W +: DATA_W];
               state_d    = WRITE;
            end
         end
         WRITE: begin
            ack_d   = gnt_q;
            ptr_d   = (win_q == PTR_W'(N_REQ-1)) ? '0 : win_q + 1'b1;
            state_d = IDLE;
`ifdef REG_BANK_ARBITER_WPROT_EN
            bank_we = ~wprot[cap_addr_q];
            err_d   = wprot[cap_addr_q];
`else
            bank_we = 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ack_q      <= '0;
         ptr_q      <= '0;
         win_q      <= '0;
         cap_addr_q <= '0;
         cap_data_q <= '0;
`ifdef REG_BANK_ARBITER_WPROT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         cap_addr_q <= cap_addr_d;
         cap_data_q <= cap_data_d;
`ifdef REG_BANK_ARBITER_WPROT_EN
         err_q      <= err_d;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
      end else if (bank_we) begin
         bank_q[cap_addr_q] <= cap_data_q;
      end
   end

   assign gnt     = gnt_q;
   assign ack     = ack_q;
   assign busy    = (state_q == WRITE);
   assign rd_data = bank_q[rd_addr];
`ifdef REG_BANK_ARBITER_WPROT_EN
   assign err     = err_q;
`endif

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, single write, contention, rotation, reset mid-write, protect.
module tb_reg_bank_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] wr_addr;
   logic [N_REQ*DATA_W-1:0] wr_data;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        ack;
   logic                    busy;
   logic [ADDR_W-1:0]       rd_addr;
   logic [DATA_W-1:0]       rd_data;
`ifdef REG_BANK_ARBITER_WPROT_EN
   logic [(2**ADDR_W)-1:0]  wprot;
   logic                    err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   reg_bank_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .gnt     (gnt),
      .ack     (ack),
      .busy    (busy),
`ifdef REG_BANK_ARBITER_WPROT_EN
      .wprot   (wprot),
      .err     (err),
`endif
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rd(input string tag, input int a, input logic [7:0] exp);
      rd_addr = ADDR_W'(a);
      #1;
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   task automatic set_wr(input int r, input int a, input logic [7:0] d);
      wr_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wr_data[r*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      logic [7:0] cdat [4];
      cdat[0] = 8'h11; cdat[1] = 8'h22; cdat[2] = 8'h33; cdat[3] = 8'h44;
      reset   = 1'b0;
      req     = 4'($urandom);
      wr_addr = 8'($urandom);
      wr_data = 32'($urandom);
      rd_addr = '0;
`ifdef REG_BANK_ARBITER_WPROT_EN
      wprot   = '0;
`endif
      // Reset held with random inputs
      repeat (3) tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      for (int a = 0; a < 4; a++) chk_rd($sformatf("rst_rd%0d", a), a, 8'h00);

      // Single write, requester drops req one cycle late
      req = '0;
      reset = 1'b1;
      tick();
      set_wr(0, 2, 8'hA5);
      req = 4'b0001;
      tick();
      chk("sw_gnt", 32'(gnt), 32'b0001);
      chk("sw_busy", 32'(busy), 1);
      chk("sw_ack0", 32'(ack), 0);
      tick();
      chk("sw_ack", 32'(ack), 32'b0001);
      chk("sw_gnt_clr", 32'(gnt), 0);
      chk("sw_busy_clr", 32'(busy), 0);
      chk_rd("sw_rd", 2, 8'hA5);
      tick();
      chk("sw_nodup_gnt", 32'(gnt), 0);
      chk("sw_ack_1cyc", 32'(ack), 0);
      chk("sw_nodup_busy", 32'(busy), 0);
      req = '0;
      tick();
      chk("sw_idle_gnt", 32'(gnt), 0);

      // Full contention from reset
      reset = 1'b0;
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_wr(i, i, cdat[i]);
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("fc_gnt%0d", i), 32'(gnt), 32'(1 << i));
         chk($sformatf("fc_ack%0d_lo", i), 32'(ack), 0);
         tick();
         chk($sformatf("fc_ack%0d", i), 32'(ack), 32'(1 << i));
         chk($sformatf("fc_gnt%0d_clr", i), 32'(gnt), 0);
         req[i] = 1'b0;
      end
      tick();
      chk("fc_done_ack", 32'(ack), 0);
      chk("fc_done_gnt", 32'(gnt), 0);
      for (int a = 0; a < 4; a++) chk_rd($sformatf("fc_rd%0d", a), a, cdat[a]);

      // Rotation: ack requester 1 -> ptr=2, then req0+req3 -> 3 wins first
      set_wr(1, 1, 8'h5B);
      req = 4'b0010;
      tick();
      chk("rot_gnt1", 32'(gnt), 32'b0010);
      tick();
      chk("rot_ack1", 32'(ack), 32'b0010);
      req = '0;
      tick();
      set_wr(0, 0, 8'hC0);
      set_wr(3, 3, 8'hC3);
      req = 4'b1001;
      tick();
      chk("rot_gnt3", 32'(gnt), 32'b1000);
      tick();
      chk("rot_ack3", 32'(ack), 32'b1000);
      req = 4'b0001;
      tick();
      chk("rot_gnt0", 32'(gnt), 32'b0001);
      tick();
      chk("rot_ack0", 32'(ack), 32'b0001);
      req = '0;
      chk_rd("rot_rd1", 1, 8'h5B);
      chk_rd("rot_rd3", 3, 8'hC3);
      chk_rd("rot_rd0", 0, 8'hC0);
      tick();

      // Reset asserted mid-write
      set_wr(1, 1, 8'h3C);
      req = 4'b0010;
      tick();
      chk("rmw_busy", 32'(busy), 1);
      chk("rmw_gnt", 32'(gnt), 32'b0010);
      reset = 1'b0;
      #1;
      chk("rmw_gnt_now", 32'(gnt), 0);
      chk("rmw_busy_now", 32'(busy), 0);
      chk_rd("rmw_rd1", 1, 8'h00);
      req = '0;
      tick();
      chk("rmw_ack_in_rst", 32'(ack), 0);
      reset = 1'b1;
      tick();
      chk("rmw_ack_after", 32'(ack), 0);
      chk_rd("rmw_rd1_after", 1, 8'h00);

`ifdef REG_BANK_ARBITER_WPROT_EN
      // Write protect on address 1
      wprot = 4'b0010;
      set_wr(2, 1, 8'hFF);
      req = 4'b0100;
      tick();
      chk("wp_gnt2", 32'(gnt), 32'b0100);
      chk("wp_err_lo", 32'(err), 0);
      tick();
      chk("wp_ack2", 32'(ack), 32'b0100);
      chk("wp_err", 32'(err), 1);
      chk_rd("wp_rd1", 1, 8'h00);
      req = '0;
      tick();
      chk("wp_err_1cyc", 32'(err), 0);
      set_wr(0, 0, 8'h5A);
      req = 4'b0001;
      tick();
      chk("wp_gnt0", 32'(gnt), 32'b0001);
      tick();
      chk("wp_ack0", 32'(ack), 32'b0001);
      chk("wp_err0", 32'(err), 0);
      chk_rd("wp_rd0", 0, 8'h5A);
      req = '0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
